// File: rtl/conv_1x1_pkg.sv
// Shared types and helpers for the 1x1-conv weight buffer path.
package conv_1x1_pkg;

    typedef enum logic [1:0] {StIdle, StWait, StLoad, StDone} state_e;

    localparam int unsigned DefInCh      = 64;
    localparam int unsigned DefOutCh     = 256;
    localparam int unsigned DefFifoDepth = 1024;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_1x1_occ_counter.sv
// Up/down FIFO occupancy counter with full-hold and sticky overflow flag.
module conv_1x1_occ_counter #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (inc && !dec) begin
            // A write into a full FIFO is dropped by the buffer, so the count holds.
            if (count_q == CNT_W'(DEPTH)) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (dec && !inc && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/conv_1x1_weight_sched.sv
// Weight FIFO read scheduler: issues IN_CH-long load bursts per filter once resident.
// Optional CONV1X1_STALL_CNT_EN adds a saturating WAIT-cycle counter output.
module conv_1x1_weight_sched
    import conv_1x1_pkg::*;
#(
    parameter int unsigned IN_CH      = DefInCh,
    parameter int unsigned OUT_CH     = DefOutCh,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth,
    parameter int unsigned CNT_W      = 11
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           w_valid_in,
    input  logic                           start,
    output logic                           load_weights,
    output logic                           weight_valid,
    output logic                           ch_last,
    output logic [idx_width(OUT_CH)-1:0]   filter_idx,
    output logic [CNT_W-1:0]               occupancy,
    output logic                           busy,
    output logic                           done,
`ifdef CONV1X1_STALL_CNT_EN
    output logic [31:0]                    stall_cycles,
`endif
    output logic                           overflow
);

    localparam int unsigned CH_W   = idx_width(IN_CH);
    localparam int unsigned FIDX_W = idx_width(OUT_CH);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_cnt_q, ch_cnt_d;
    logic [FIDX_W-1:0]   filter_idx_q, filter_idx_d;
    logic                wr_q;
    logic                weight_valid_q, ch_last_q;
    logic                last_ch;
    logic [CNT_W:0]      occ_after;

    // wr_q mirrors the weight DFF stage, so it is the actual FIFO write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= 1'b0;
        end else begin
            wr_q <= w_valid_in;
        end
    end

    conv_1x1_occ_counter #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk      (clk),
        .reset    (reset),
        .inc      (wr_q),
        .dec      (load_weights),
        .count    (occupancy),
        .overflow (overflow)
    );

    assign last_ch   = (state_q == StLoad) && (ch_cnt_q == CH_W'(IN_CH - 1));
    // Occupancy after this cycle's read, used to chain bursts without a bubble.
    assign occ_after = {1'b0, occupancy} + {{CNT_W{1'b0}}, wr_q} - (CNT_W + 1)'(1);

    always_comb begin
        state_d      = state_q;
        ch_cnt_d     = ch_cnt_q;
        filter_idx_d = filter_idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d      = StWait;
                    ch_cnt_d     = '0;
                    filter_idx_d = '0;
                end
            end
            StWait: begin
                if (occupancy >= CNT_W'(IN_CH)) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                if (last_ch) begin
                    ch_cnt_d = '0;
                    if (filter_idx_q == FIDX_W'(OUT_CH - 1)) begin
                        state_d = StDone;
                    end else begin
                        filter_idx_d = filter_idx_q + FIDX_W'(1);
                        state_d      = (occ_after >= (CNT_W + 1)'(IN_CH)) ? StLoad : StWait;
                    end
                end else begin
                    ch_cnt_d = ch_cnt_q + CH_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            ch_cnt_q       <= '0;
            filter_idx_q   <= '0;
            weight_valid_q <= 1'b0;
            ch_last_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ch_cnt_q       <= ch_cnt_d;
            filter_idx_q   <= filter_idx_d;
            weight_valid_q <= load_weights;
            ch_last_q      <= last_ch;
        end
    end

    always_comb begin
        load_weights = (state_q == StLoad);
        busy         = (state_q == StWait) || (state_q == StLoad);
        done         = (state_q == StDone);
    end

    assign weight_valid = weight_valid_q;
    assign ch_last      = ch_last_q;
    assign filter_idx   = filter_idx_q;

`ifdef CONV1X1_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else if ((state_q == StIdle) && start) begin
            stall_q <= '0;
        end else if ((state_q == StWait) && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule
